vscpu_core_param: RTL and testbench

- Parametrised next-generation VerySimple CPU core.
- Same 16-opcode memory-to-memory ISA, with generic address/data widths.
- Uses a req/ack memory handshake that tolerates wait states, plus run/halt control and a retired-instruction counter.
- Sits between the system RAM or arbiter and the top-level test harness.

---
 rtl/vscpu_pkg.sv | 48 ++++
 rtl/vscpu_alu.sv | 36 +++
 rtl/vscpu_core_param.sv | 194 +++++++++++++++++++
 tb/tb_vscpu_core_param.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscpu_pkg.sv
// Shared definitions for the VerySimple CPU core: opcodes, FSM states and
// instruction field extraction. The helpers operate on a MAX_W-bit word,
// so DATA_W must not exceed MAX_W.
// Optional feature macro: VSCPU_MUL_EN (see vscpu_alu / vscpu_core_param).
package vscpu_pkg;

    localparam int MAX_W = 64;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_LT   = 3'd3;
    localparam logic [2:0] OP_CP   = 3'd4;
    localparam logic [2:0] OP_CPI  = 3'd5;
    localparam logic [2:0] OP_BZJ  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RD_A,
        RD_B,
        RD_IND,
        WRITE,
        HALT
    } state_t;

    // Opcode sits in the top three bits of the instruction word.
    function automatic logic [2:0] get_op(input logic [MAX_W-1:0] word, input int data_w);
        return 3'((word >> (data_w - 3)) & 64'd7);
    endfunction

    // Immediate flag is the bit just below the opcode.
    function automatic logic get_imm(input logic [MAX_W-1:0] word, input int data_w);
        return 1'((word >> (data_w - 4)) & 64'd1);
    endfunction

    // A field: bits [2*addr_w-1:addr_w].
    function automatic logic [MAX_W-1:0] get_a(input logic [MAX_W-1:0] word, input int addr_w);
        return (word >> addr_w) & ((64'd1 << addr_w) - 64'd1);
    endfunction

    // B field: bits [addr_w-1:0].
    function automatic logic [MAX_W-1:0] get_b(input logic [MAX_W-1:0] word, input int addr_w);
        return word & ((64'd1 << addr_w) - 64'd1);
    endfunction

endpackage

// File: rtl/vscpu_alu.sv
// Combinational ALU for the VerySimple CPU. The multiplier only exists
// when VSCPU_MUL_EN is defined; otherwise MUL yields zero (never used,
// because the core retires MUL as a NOP in that build).
module vscpu_alu #(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    import vscpu_pkg::*;

    localparam logic [DATA_W-1:0] W1 = DATA_W'(DATA_W);
    localparam logic [DATA_W-1:0] W2 = DATA_W'(2 * DATA_W);

    // Result selection; SRL turns into a left shift for amounts in [W, 2W).
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_NAND: y = ~(a & b);
            OP_SRL: begin
                if (b < W1)      y = a >> b;
                else if (b < W2) y = a << (b - W1);
                else             y = '0;
            end
            OP_LT:   y = (a < b) ? DATA_W'(1) : '0;
`ifdef VSCPU_MUL_EN
            OP_MUL:  y = a * b;
`endif
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vscpu_core_param.sv
// Parametrised VerySimple CPU core with a req/ack memory port.
// Every access holds mem_req/addr/we/wdata stable until the edge with
// mem_ack=1. run is only looked at in IDLE, so instructions never stop
// half way. A branch that targets its own address halts the core
// (the halting branch itself still counts as retired).
// Optional feature macro: VSCPU_MUL_EN enables MUL/MULi.
module vscpu_core_param #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);
    import vscpu_pkg::*;

`ifdef VSCPU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir, ra, rb;

    // Fields of the word arriving during FETCH and of the latched ir
    logic [2:0]        f_op, i_op;
    logic              f_imm, i_imm;
    logic [ADDR_W-1:0] f_a, f_b, i_a, i_b;
    logic [DATA_W-1:0] b_ext;

    assign f_op  = get_op(MAX_W'(mem_rdata), DATA_W);
    assign f_imm = get_imm(MAX_W'(mem_rdata), DATA_W);
    assign f_a   = ADDR_W'(get_a(MAX_W'(mem_rdata), ADDR_W));
    assign f_b   = ADDR_W'(get_b(MAX_W'(mem_rdata), ADDR_W));
    assign i_op  = get_op(MAX_W'(ir), DATA_W);
    assign i_imm = get_imm(MAX_W'(ir), DATA_W);
    assign i_a   = ADDR_W'(get_a(MAX_W'(ir), ADDR_W));
    assign i_b   = ADDR_W'(get_b(MAX_W'(ir), ADDR_W));
    assign b_ext = DATA_W'(i_b);

    // ALU operands: immediate forms compute as *A arrives (RD_A),
    // register forms compute as *B arrives (RD_B).
    logic [DATA_W-1:0] alu_a, alu_b, alu_y;
    assign alu_a = (state == RD_A) ? mem_rdata : ra;
    assign alu_b = (state == RD_B) ? mem_rdata : (i_imm ? b_ext : rb);

    vscpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op (i_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    logic [ADDR_W-1:0] pc_inc, br_pc;
    logic [CNT_W-1:0]  retired_inc;
    assign pc_inc      = pc + ADDR_W'(1);
    assign br_pc       = (state == RD_A) ? ADDR_W'(mem_rdata + b_ext)
                                         : ((mem_rdata == '0) ? ra[ADDR_W-1:0] : pc_inc);
    assign retired_inc = (retired == '1) ? retired : retired + CNT_W'(1);
    assign pc_o        = pc;

    // Main FSM: state, architectural registers and registered memory port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            ra        <= '0;
            rb        <= '0;
            retired   <= '0;
            halted    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        if (f_op == OP_MUL && !MUL_EN) begin
                            pc      <= pc_inc;
                            retired <= retired_inc;
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end else if (f_op == OP_CP && f_imm) begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= f_a;
                            mem_wdata <= DATA_W'(f_b);
                        end else if (f_op == OP_CP || (f_op == OP_CPI && !f_imm)) begin
                            state    <= RD_B;
                            mem_addr <= f_b;
                        end else begin
                            state    <= RD_A;
                            mem_addr <= f_a;
                        end
                    end
                end
                RD_A: begin
                    if (mem_ack) begin
                        ra <= mem_rdata;
                        if (i_op == OP_BZJ && i_imm) begin
                            pc      <= br_pc;
                            retired <= retired_inc;
                            mem_req <= 1'b0;
                            if (br_pc == pc) begin
                                halted <= 1'b1;
                                state  <= HALT;
                            end else begin
                                state  <= IDLE;
                            end
                        end else if (i_imm && i_op != OP_CPI) begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= i_a;
                            mem_wdata <= alu_y;
                        end else begin
                            state    <= RD_B;
                            mem_addr <= i_b;
                        end
                    end
                end
                RD_B: begin
                    if (mem_ack) begin
                        rb <= mem_rdata;
                        if (i_op == OP_BZJ) begin
                            pc      <= br_pc;
                            retired <= retired_inc;
                            mem_req <= 1'b0;
                            if (br_pc == pc) begin
                                halted <= 1'b1;
                                state  <= HALT;
                            end else begin
                                state  <= IDLE;
                            end
                        end else if (i_op == OP_CPI && !i_imm) begin
                            state    <= RD_IND;
                            mem_addr <= mem_rdata[ADDR_W-1:0];
                        end else begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= (i_op == OP_CPI) ? ra[ADDR_W-1:0] : i_a;
                            mem_wdata <= (i_op == OP_CP || i_op == OP_CPI) ? mem_rdata : alu_y;
                        end
                    end
                end
                RD_IND: begin
                    if (mem_ack) begin
                        state     <= WRITE;
                        mem_we    <= 1'b1;
                        mem_addr  <= i_a;
                        mem_wdata <= mem_rdata;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        pc      <= pc_inc;
                        retired <= retired_inc;
                        state   <= IDLE;
                    end
                end
                HALT: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vscpu_core_param.sv
// Directed bench for vscpu_core_param (ADDR_W=14, DATA_W=32, CNT_W=32).
// A behavioural RAM answers requests with a programmable 0..max_wait
// cycle ack delay and tracks request/handshake stability.
module tb_vscpu_core_param;

    localparam logic [2:0] T_ADD  = 3'd0;
    localparam logic [2:0] T_NAND = 3'd1;
    localparam logic [2:0] T_SRL  = 3'd2;
    localparam logic [2:0] T_LT   = 3'd3;
    localparam logic [2:0] T_CP   = 3'd4;
    localparam logic [2:0] T_CPI  = 3'd5;
    localparam logic [2:0] T_BZJ  = 3'd6;
    localparam logic [2:0] T_MUL  = 3'd7;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        run = 0;
    logic        mem_req, mem_we, mem_ack = 0;
    logic [13:0] mem_addr, pc_o;
    logic [31:0] mem_wdata, mem_rdata = 0, retired;
    logic        halted;

    vscpu_core_param #(.ADDR_W(14), .DATA_W(32), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_o      (pc_o),
        .halted    (halted),
        .retired   (retired)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model and monitors
    logic [31:0] mem [0:16383];
    int          max_wait = 0;
    int          wcnt = -1;
    int          req_cycles = 0, wr_count = 0, stable_viol = 0, wait_cycles = 0;
    logic        prev_wait = 0, p_we = 0;
    logic [13:0] p_addr = 0;
    logic [31:0] p_wdata = 0;

    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ack = 1'b0;
            wcnt = -1;
        end else begin
            if (wcnt < 0) wcnt = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
            if (wcnt == 0) begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr];
                wcnt = -1;
            end else begin
                mem_ack = 1'b0;
                wcnt = wcnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (mem_req) req_cycles = req_cycles + 1;
            if (mem_req && mem_ack && mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr_count = wr_count + 1;
            end
            if (prev_wait && (!mem_req || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
                stable_viol = stable_viol + 1;
            prev_wait = mem_req && !mem_ack;
            if (prev_wait) wait_cycles = wait_cycles + 1;
            p_addr  = mem_addr;
            p_we    = mem_we;
            p_wdata = mem_wdata;
        end else begin
            prev_wait = 1'b0;
        end
    end

    // Scoreboard
    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver tasks
    function automatic logic [31:0] enc(input logic [2:0] op, input logic imm,
                                        input logic [13:0] a, input logic [13:0] b);
        return {op, imm, a, b};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        run = 0;
        max_wait = 0;
        repeat (2) @(negedge clk);
        req_cycles = 0;
        wr_count = 0;
        stable_viol = 0;
        wait_cycles = 0;
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int n = 0;
        run = 1;
        while (retired != 32'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        run = 0;
        if (retired != 32'(target)) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: retired %0d expected %0d", name, retired, target);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        imm;
        logic [31:0] a_val;
        logic [31:0] b_val;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] e;
        int          r0;

        // Table: instruction at 0, *A at 100, *B at 101 (or B field for imm)
        vecs[0]  = '{T_ADD,  1'b0, 32'd5,          32'd7,          32'd12};
        vecs[1]  = '{T_NAND, 1'b0, 32'hFF00FF00,   32'h0F0F0F0F,   32'hF0FFF0FF};
        vecs[2]  = '{T_SRL,  1'b0, 32'h80000000,   32'd31,         32'h00000001};
        vecs[3]  = '{T_SRL,  1'b0, 32'h80000000,   32'd33,         32'h00000000};
        vecs[4]  = '{T_SRL,  1'b0, 32'h80000000,   32'd32,         32'h80000000};
        vecs[5]  = '{T_SRL,  1'b1, 32'h000000F0,   32'd4,          32'h0000000F};
        vecs[6]  = '{T_SRL,  1'b0, 32'h00000001,   32'd63,         32'h80000000};
        vecs[7]  = '{T_SRL,  1'b0, 32'hFFFFFFFF,   32'd64,         32'h00000000};
        vecs[8]  = '{T_LT,   1'b0, 32'd3,          32'd5,          32'd1};
        vecs[9]  = '{T_LT,   1'b0, 32'hFFFFFFFF,   32'd1,          32'd0};
        vecs[10] = '{T_LT,   1'b1, 32'd2,          32'd100,        32'd1};
        vecs[11] = '{T_ADD,  1'b1, 32'hFFFFFFFF,   32'd1,          32'd0};
        vecs[12] = '{T_CP,   1'b0, 32'h00000011,   32'h00001234,   32'h00001234};
        vecs[13] = '{T_CP,   1'b1, 32'h00000011,   32'h000002AB,   32'h000002AB};
        vecs[14] = '{T_NAND, 1'b1, 32'hFFFFFFFF,   32'h00003FFF,   32'hFFFFC000};
`ifdef VSCPU_MUL_EN
        vecs[15] = '{T_MUL,  1'b0, 32'd3,          32'd7,          32'd21};
        vecs[16] = '{T_MUL,  1'b1, 32'd6,          32'd9,          32'd54};
`else
        vecs[15] = '{T_MUL,  1'b0, 32'd3,          32'd7,          32'd3};
        vecs[16] = '{T_MUL,  1'b1, 32'd6,          32'd9,          32'd6};
`endif
        for (int i = 0; i < 17; i++) exp_q.push_back(vecs[i].exp);

        // Reset values, checked while rst_n is still low
        rst_n = 0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_pc", {18'd0, pc_o}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_retired", retired, 32'd0);

        // Table-driven single-instruction vectors
        for (int i = 0; i < 17; i++) begin
            do_reset();
            clear_mem();
            mem[0]   = enc(vecs[i].op, vecs[i].imm, 14'd100,
                           vecs[i].imm ? vecs[i].b_val[13:0] : 14'd101);
            mem[100] = vecs[i].a_val;
            mem[101] = vecs[i].b_val;
            run_until(1, 40, $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("vec%0d_result", i), mem[100], e);
            check($sformatf("vec%0d_pc", i), {18'd0, pc_o}, 32'd1);
            check($sformatf("vec%0d_retired", i), retired, 32'd1);
        end

        // ADD zero-wait timing: four accesses, each one request cycle
        do_reset();
        clear_mem();
        mem[0] = enc(T_ADD, 1'b0, 14'd100, 14'd101);
        mem[100] = 32'd5;
        mem[101] = 32'd7;
        run_until(1, 40, "add_timing");
        check("add_req_cycles", 32'(req_cycles), 32'd4);
        check("add_writes", 32'(wr_count), 32'd1);

        // CPI with random wait states, repeated so waits certainly occur
        do_reset();
        clear_mem();
        mem[0] = enc(T_CPI, 1'b0, 14'd200, 14'd201);
        mem[1] = enc(T_CPI, 1'b0, 14'd210, 14'd201);
        mem[2] = enc(T_CPI, 1'b0, 14'd211, 14'd201);
        mem[3] = enc(T_CPI, 1'b0, 14'd212, 14'd201);
        mem[201] = 32'd300;
        mem[300] = 32'hDEADBEEF;
        max_wait = 3;
        run_until(4, 400, "cpi_wait");
        repeat (2) @(negedge clk);
        check("cpi_mem200", mem[200], 32'hDEADBEEF);
        check("cpi_mem210", mem[210], 32'hDEADBEEF);
        check("cpi_mem212", mem[212], 32'hDEADBEEF);
        check("cpi_pc", {18'd0, pc_o}, 32'd4);
        check("cpi_stable_viol", 32'(stable_viol), 32'd0);
        check("cpi_waits_seen", {31'd0, wait_cycles > 0}, 32'd1);

        // CPIi: *(*A) = *B
        do_reset();
        clear_mem();
        mem[0] = enc(T_CPI, 1'b1, 14'd100, 14'd101);
        mem[100] = 32'd150;
        mem[101] = 32'h0000CAFE;
        run_until(1, 40, "cpii");
        repeat (2) @(negedge clk);
        check("cpii_target", mem[150], 32'h0000CAFE);
        check("cpii_ptr_kept", mem[100], 32'd150);

        // Branch chain: BZJ not taken, BZJi to 5, BZJ self-loop halt
        do_reset();
        clear_mem();
        mem[0] = enc(T_BZJ, 1'b0, 14'd70, 14'd71);
        mem[70] = 32'd33;
        mem[71] = 32'd9;
        mem[1] = enc(T_BZJ, 1'b1, 14'd60, 14'd4);
        mem[60] = 32'd1;
        mem[5] = enc(T_BZJ, 1'b0, 14'd50, 14'd51);
        mem[50] = 32'd5;
        mem[51] = 32'd0;
        run_until(1, 40, "bzj_nt");
        check("bzj_nt_pc", {18'd0, pc_o}, 32'd1);
        run_until(2, 40, "bzji");
        check("bzji_pc", {18'd0, pc_o}, 32'd5);
        check("bzji_not_halted", {31'd0, halted}, 32'd0);
        run_until(3, 40, "bzj_halt");
        @(negedge clk);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc", {18'd0, pc_o}, 32'd5);
        r0 = req_cycles;
        run = 1;
        repeat (20) @(negedge clk);
        run = 0;
        check("halt_no_req", 32'(req_cycles - r0), 32'd0);
        check("halt_retired_frozen", retired, 32'd3);

        // PC wrap at 0x3FFF and run gating
        do_reset();
        clear_mem();
        mem[0] = enc(T_BZJ, 1'b1, 14'd60, 14'd0);
        mem[60] = 32'h00003FFF;
        mem[16383] = enc(T_CP, 1'b1, 14'd80, 14'h0055);
        run_until(1, 40, "wrap_jump");
        check("wrap_jump_pc", {18'd0, pc_o}, 32'h3FFF);
        run_until(2, 40, "wrap_cpi");
        repeat (2) @(negedge clk);
        check("wrap_pc", {18'd0, pc_o}, 32'd0);
        check("wrap_cpi_data", mem[80], 32'h55);
        r0 = req_cycles;
        repeat (10) @(negedge clk);
        check("gate_no_req", 32'(req_cycles - r0), 32'd0);
        check("gate_retired", retired, 32'd2);
        run_until(3, 40, "resume");
        check("resume_pc", {18'd0, pc_o}, 32'h3FFF);

        // MUL cost: product path or single-fetch NOP
        do_reset();
        clear_mem();
        mem[0] = enc(T_MUL, 1'b0, 14'd100, 14'd101);
        mem[100] = 32'd3;
        mem[101] = 32'd7;
        run_until(1, 40, "mul");
        repeat (2) @(negedge clk);
`ifdef VSCPU_MUL_EN
        check("mul_req_cycles", 32'(req_cycles), 32'd4);
        check("mul_writes", 32'(wr_count), 32'd1);
        check("mul_result", mem[100], 32'd21);
`else
        check("mul_req_cycles", 32'(req_cycles), 32'd1);
        check("mul_writes", 32'(wr_count), 32'd0);
        check("mul_result", mem[100], 32'd3);
`endif
        check("mul_pc", {18'd0, pc_o}, 32'd1);

        // Reset asserted while the second instruction is in RD_B
        do_reset();
        clear_mem();
        mem[0] = enc(T_CP, 1'b1, 14'd80, 14'd3);
        mem[1] = enc(T_ADD, 1'b0, 14'd100, 14'd101);
        mem[100] = 32'd5;
        mem[101] = 32'd7;
        run = 1;
        r0 = 0;
        while (!(retired == 32'd1 && mem_req && !mem_we && mem_addr == 14'd101) && r0 < 50) begin
            @(negedge clk);
            r0++;
        end
        check("midrst_reached_rd_b", {31'd0, r0 < 50}, 32'd1);
        rst_n = 0;
        run = 0;
        #1;
        check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        check("midrst_mem_addr", {18'd0, mem_addr}, 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        check("midrst_pc", {18'd0, pc_o}, 32'd0);
        check("midrst_retired", retired, 32'd0);
        check("midrst_halted", {31'd0, halted}, 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_no_write", mem[100], 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
